uart_fifo_port: RTL and testbench

Processor-side UART port controller that sits between the tramelblaze port bus and the existing serial tx/rx engines. It replaces single-byte handoff with parametrised TX and RX FIFOs. It adds a control register that drives the engine frame/baud inputs, sticky error and overflow status, and a maskable edge-triggered interrupt with acknowledge.

---
 rtl/uart_fifo_port.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_fifo_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_port.sv
// Port-bus UART front end: TX/RX FIFOs, ctrl/status/ie registers, edge-triggered interrupt.
// Optional `UART_LOOPBACK_EN: ctrl[7] routes the TX FIFO straight into the RX FIFO.
module uart_fifo_port #(
   parameter int          DEPTH     = 16,
   parameter int          AW        = 4,
   parameter logic [15:0] PORT_BASE = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] port_id,
   input  logic [15:0] out_port,
   input  logic        write_strobe,
   input  logic        read_strobe,
   output logic [15:0] in_port,
   output logic        interrupt,
   input  logic        int_ack,
   output logic [7:0]  tx_data,
   output logic        tx_load,
   input  logic        txrdy,
   input  logic [7:0]  rx_data,
   input  logic        rxrdy,
   input  logic        ferr,
   input  logic        perr,
   output logic        rx_clr,
   output logic [3:0]  baud,
   output logic        eight,
   output logic        pen,
   output logic        ohel
);

   localparam logic [15:0] A_DATA = PORT_BASE;
   localparam logic [15:0] A_STAT = PORT_BASE + 16'd1;
   localparam logic [15:0] A_IE   = PORT_BASE + 16'd2;
   localparam logic [15:0] A_CTRL = PORT_BASE + 16'd3;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

   logic [7:0]    tx_mem [DEPTH];
   logic [9:0]    rx_mem [DEPTH];

   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0]    ctrl_q, ctrl_d;
   logic [2:0]    ie_q, ie_d;
   logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
   logic          rxrdy_q, rxrdy_d;
   logic          rx_clr_q, rx_clr_d;
   logic          src_q, src_d;
   logic          int_q, int_d;

   tx_state_t     tx_state_q;
   logic          tx_load_q;
   logic [7:0]    tx_data_q;

   logic          wr_data, wr_ie, wr_ctrl, rd_data, rd_stat;
   logic          tx_full, tx_empty, rx_full, rx_empty, tx_idle;
   logic          tx_push, tx_push_ok, tx_pop, tx_start, tx_lb;
   logic          rx_push, rx_push_ok, rx_pop, rx_edge;
   logic [9:0]    rx_wdat;
   logic [7:0]    tx_head;
   logic [9:0]    rx_head;
   logic [7:0]    stat;
   logic [2:0]    src;
   logic          loop_on;
   logic          unused_bits;

   assign unused_bits = ^out_port[15:8];

`ifdef UART_LOOPBACK_EN
   assign loop_on = ctrl_q[7];
`else
   assign loop_on = 1'b0;
`endif

   assign wr_data  = write_strobe && (port_id == A_DATA);
   assign wr_ie    = write_strobe && (port_id == A_IE);
   assign wr_ctrl  = write_strobe && (port_id == A_CTRL);
   assign rd_data  = read_strobe  && (port_id == A_DATA);
   assign rd_stat  = read_strobe  && (port_id == A_STAT);

   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_head  = tx_mem[tx_rp_q];
   assign rx_head  = rx_mem[rx_rp_q];
   assign tx_idle  = tx_empty && (tx_state_q == TX_IDLE) && txrdy;

   assign stat = {rx_full, tx_ovf_q, rx_ovf_q,
                  rx_head[9] & ~rx_empty, rx_head[8] & ~rx_empty,
                  tx_idle, ~tx_full, ~rx_empty};

   // Processor read mux is purely combinational on port_id.
   always_comb begin
      in_port = '0;
      if (port_id == A_DATA) begin
         if (!rx_empty) in_port = {6'b0, rx_head};
      end else if (port_id == A_STAT) begin
         in_port = {8'(rx_cnt_q), stat};
      end else if (port_id == A_IE) begin
         in_port = {13'b0, ie_q};
      end else if (port_id == A_CTRL) begin
         in_port = {8'b0, ctrl_q};
      end
   end

   always_comb begin
      tx_start = 1'b0;
      tx_lb    = 1'b0;
      if (tx_state_q == TX_IDLE && !tx_empty) begin
         if (loop_on)    tx_lb    = 1'b1;
         else if (txrdy) tx_start = 1'b1;
      end
      tx_pop     = tx_start | tx_lb;
      tx_push    = wr_data;
      tx_push_ok = tx_push && !tx_full;

      rx_edge = rxrdy && !rxrdy_q && !loop_on;
      rx_push = rx_edge;
      rx_wdat = {ferr, perr, rx_data};
`ifdef UART_LOOPBACK_EN
      if (tx_lb) begin
         rx_push = 1'b1;
         rx_wdat = {2'b00, tx_head};
      end
`endif
      // Fullness is judged at start of cycle, so a same-cycle pop cannot rescue a push.
      rx_push_ok = rx_push && !rx_full;
      rx_pop     = rd_data && !rx_empty;
   end

   always_comb begin
      tx_wp_d  = tx_push_ok ? tx_wp_q + AW'(1) : tx_wp_q;
      tx_rp_d  = tx_pop     ? tx_rp_q + AW'(1) : tx_rp_q;
      rx_wp_d  = rx_push_ok ? rx_wp_q + AW'(1) : rx_wp_q;
      rx_rp_d  = rx_pop     ? rx_rp_q + AW'(1) : rx_rp_q;

      tx_cnt_d = tx_cnt_q;
      case ({tx_push_ok, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + (AW+1)'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - (AW+1)'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
      rx_cnt_d = rx_cnt_q;
      case ({rx_push_ok, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + (AW+1)'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - (AW+1)'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase

      tx_ovf_d = rd_stat ? 1'b0 : tx_ovf_q;
      if (tx_push && tx_full) tx_ovf_d = 1'b1;
      rx_ovf_d = rd_stat ? 1'b0 : rx_ovf_q;
      if (rx_push && rx_full) rx_ovf_d = 1'b1;

      ctrl_d = ctrl_q;
      if (wr_ctrl) begin
`ifdef UART_LOOPBACK_EN
         ctrl_d = out_port[7:0];
`else
         ctrl_d = {1'b0, out_port[6:0]};
`endif
      end
      ie_d = wr_ie ? out_port[2:0] : ie_q;

      rxrdy_d  = rxrdy;
      rx_clr_d = rx_edge;

      // ie_q feeds src, so enabling an already-true source also produces an edge.
      src   = ie_q & {tx_ovf_q | rx_ovf_q, tx_idle, ~rx_empty};
      src_d = |src;
      int_d = (src_d && !src_q) || (int_q && !int_ack);
   end

   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wp_q] <= out_port[7:0];
      if (rx_push_ok) rx_mem[rx_wp_q] <= rx_wdat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         ctrl_q   <= 8'h14;
         ie_q     <= '0;
         tx_ovf_q <= 1'b0;
         rx_ovf_q <= 1'b0;
         rxrdy_q  <= 1'b0;
         rx_clr_q <= 1'b0;
         src_q    <= 1'b0;
         int_q    <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         ctrl_q   <= ctrl_d;
         ie_q     <= ie_d;
         tx_ovf_q <= tx_ovf_d;
         rx_ovf_q <= rx_ovf_d;
         rxrdy_q  <= rxrdy_d;
         rx_clr_q <= rx_clr_d;
         src_q    <= src_d;
         int_q    <= int_d;
      end
   end

   // WAIT holds off the next load until the engine has visibly gone busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_load_q  <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_load_q <= 1'b0;
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_start) begin
                  tx_data_q  <= tx_head;
                  tx_load_q  <= 1'b1;
                  tx_state_q <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (!txrdy) tx_state_q <= TX_IDLE;
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_load   = tx_load_q;
   assign rx_clr    = rx_clr_q;
   assign interrupt = int_q;
   assign baud      = ctrl_q[3:0];
   assign eight     = ctrl_q[4];
   assign pen       = ctrl_q[5];
   assign ohel      = ctrl_q[6];

endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port: registers, TX path with engine model, RX FIFO, interrupt.
module tb_uart_fifo_port;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] port_id = '0;
   logic [15:0] out_port = '0;
   logic        write_strobe = 1'b0;
   logic        read_strobe = 1'b0;
   logic [15:0] in_port;
   logic        interrupt;
   logic        int_ack = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_load;
   logic        txrdy = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rxrdy = 1'b0;
   logic        ferr = 1'b0;
   logic        perr = 1'b0;
   logic        rx_clr;
   logic [3:0]  baud;
   logic        eight, pen, ohel;

   int total = 0;
   int bad = 0;
   int busy = 0;
   int rx_clr_cnt = 0;
   logic hold = 1'b0;
   logic [7:0] loads[$];

   uart_fifo_port #(.DEPTH(16), .AW(4), .PORT_BASE(16'h0000)) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
      .interrupt(interrupt), .int_ack(int_ack), .tx_data(tx_data), .tx_load(tx_load),
      .txrdy(txrdy), .rx_data(rx_data), .rxrdy(rxrdy), .ferr(ferr), .perr(perr),
      .rx_clr(rx_clr), .baud(baud), .eight(eight), .pen(pen), .ohel(ohel)
   );

   always #5 clk = ~clk;

   // Engine model: txrdy drops the cycle after a load and returns 100 cycles later.
   always @(posedge clk) begin
      if (reset) begin
         busy = 0;
         rx_clr_cnt = 0;
         loads.delete();
         txrdy <= !hold;
      end else begin
         if (rx_clr) rx_clr_cnt++;
         if (tx_load) begin
            loads.push_back(tx_data);
            busy = 100;
         end else if (busy > 0) begin
            busy--;
         end
         txrdy <= !hold && (busy == 0);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      write_strobe = 1'b0; read_strobe = 1'b0; int_ack = 1'b0;
      rxrdy = 1'b0; ferr = 1'b0; perr = 1'b0; port_id = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      port_id = a; out_port = d; write_strobe = 1'b1;
      @(negedge clk);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      @(negedge clk);
      port_id = a; read_strobe = 1'b1;
      #1 v = in_port;
      @(negedge clk);
      read_strobe = 1'b0;
   endtask

   task automatic peek(input logic [15:0] a, output logic [15:0] v);
      @(negedge clk);
      port_id = a;
      #1 v = in_port;
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic fe, input logic pe);
      @(negedge clk);
      rx_data = d; ferr = fe; perr = pe; rxrdy = 1'b1;
      @(negedge clk);
      rxrdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] v;
      do_reset();
      peek(16'h3, v);
      total++; if (v !== 16'h0014) begin bad++; $display("FAIL reset_ctrl got=%h exp=0014", v); end
      peek(16'h1, v);
      total++; if (v !== 16'h0006) begin bad++; $display("FAIL reset_stat got=%h exp=0006", v); end
      peek(16'h2, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_ie got=%h exp=0000", v); end
      peek(16'h4, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL unmapped_rd got=%h exp=0000", v); end
      total++;
      if ({interrupt, tx_load, rx_clr} !== 3'b000) begin
         bad++; $display("FAIL reset_outs got=%b exp=000", {interrupt, tx_load, rx_clr});
      end
      total++;
      if ({ohel, pen, eight, baud} !== 7'b0010100) begin
         bad++; $display("FAIL reset_cfg got=%b exp=0010100", {ohel, pen, eight, baud});
      end
   endtask

   task automatic test_ctrl();
      logic [15:0] v;
      do_reset();
      wr(16'h3, 16'h002B);
      @(negedge clk);
      total++;
      if ({ohel, pen, eight, baud} !== 7'b0101011) begin
         bad++; $display("FAIL ctrl_outs got=%b exp=0101011", {ohel, pen, eight, baud});
      end
      wr(16'h2, 16'h00FF);
      peek(16'h2, v);
      total++; if (v !== 16'h0007) begin bad++; $display("FAIL ie_rw got=%h exp=0007", v); end
`ifndef UART_LOOPBACK_EN
      wr(16'h3, 16'h0094);
      peek(16'h3, v);
      total++; if (v !== 16'h0014) begin bad++; $display("FAIL ctrl7_masked got=%h exp=0014", v); end
`endif
   endtask

   task automatic test_tx();
      logic [15:0] v;
      do_reset();
      wr(16'h0, 16'h00A5);
      peek(16'h1, v);
      total++; if (v[2] !== 1'b0) begin bad++; $display("FAIL tx_busy_idle got=%b exp=0", v[2]); end
      wr(16'h0, 16'h003C);
      for (int c = 0; c < 400 && loads.size() < 2; c++) @(negedge clk);
      total++; if (loads.size() !== 2) begin bad++; $display("FAIL tx_loads got=%0d exp=2", loads.size()); end
      if (loads.size() >= 2) begin
         total++; if (loads[0] !== 8'hA5) begin bad++; $display("FAIL tx_byte0 got=%h exp=a5", loads[0]); end
         total++; if (loads[1] !== 8'h3C) begin bad++; $display("FAIL tx_byte1 got=%h exp=3c", loads[1]); end
      end
      v = '0;
      for (int c = 0; c < 300 && v[2] !== 1'b1; c++) peek(16'h1, v);
      total++; if (v[2] !== 1'b1) begin bad++; $display("FAIL tx_idle_back got=%b exp=1", v[2]); end
      total++; if (loads.size() !== 2) begin bad++; $display("FAIL tx_loads_final got=%0d exp=2", loads.size()); end
   endtask

   task automatic test_tx_ovf();
      logic [15:0] v;
      hold = 1'b1;
      do_reset();
      for (int i = 0; i < 17; i++) wr(16'h0, 16'(8'h10 + i));
      peek(16'h1, v);
      total++; if (v !== 16'h0040) begin bad++; $display("FAIL tx_ovf_stat got=%h exp=0040", v); end
      rd(16'h1, v);
      peek(16'h1, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL tx_ovf_clr got=%h exp=0000", v); end
      hold = 1'b0;
      for (int c = 0; c < 50 && loads.size() < 1; c++) @(negedge clk);
      total++;
      if (loads.size() < 1 || loads[0] !== 8'h10) begin
         bad++; $display("FAIL tx_ovf_first got_n=%0d exp=1 byte 10", loads.size());
      end
   endtask

   task automatic test_rx_full();
      logic [15:0] v;
      do_reset();
      for (int i = 1; i <= 17; i++) rx_byte(8'(i), 1'b0, 1'b0);
      peek(16'h1, v);
      total++; if (v !== 16'h10A7) begin bad++; $display("FAIL rx_full_stat got=%h exp=10a7", v); end
      total++; if (rx_clr_cnt !== 17) begin bad++; $display("FAIL rx_clr_cnt got=%0d exp=17", rx_clr_cnt); end
      for (int i = 1; i <= 16; i++) begin
         rd(16'h0, v);
         total++; if (v !== 16'(i)) begin bad++; $display("FAIL rx_pop%0d got=%h exp=%h", i, v, 16'(i)); end
      end
      rd(16'h1, v);
      total++; if (v !== 16'h0026) begin bad++; $display("FAIL rx_ovf_rd got=%h exp=0026", v); end
      rd(16'h0, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL rx_empty_rd got=%h exp=0000", v); end
      peek(16'h1, v);
      total++; if (v !== 16'h0006) begin bad++; $display("FAIL rx_after_clr got=%h exp=0006", v); end
   endtask

   task automatic test_interrupt();
      logic [15:0] v;
      do_reset();
      wr(16'h2, 16'h0001);
      @(negedge clk);
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", interrupt); end
      rx_data = 8'h55; rxrdy = 1'b1;
      @(negedge clk);
      rxrdy = 1'b0;
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", interrupt); end
      @(negedge clk);
      total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", interrupt); end
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_ack got=%b exp=0", interrupt); end
      rx_byte(8'h66, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_no_rerise got=%b exp=0", interrupt); end
      peek(16'h1, v);
      total++; if (v[15:8] !== 8'd2) begin bad++; $display("FAIL irq_rxcount got=%0d exp=2", v[15:8]); end
      wr(16'h2, 16'h0000);
      wr(16'h2, 16'h0001);
      @(negedge clk);
      total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_ie_edge got=%b exp=1", interrupt); end
   endtask

   task automatic test_ferr();
      logic [15:0] v;
      do_reset();
      rx_byte(8'h55, 1'b1, 1'b0);
      peek(16'h1, v);
      total++; if (v !== 16'h0117) begin bad++; $display("FAIL ferr_stat got=%h exp=0117", v); end
      rd(16'h0, v);
      total++; if (v !== 16'h0255) begin bad++; $display("FAIL ferr_data got=%h exp=0255", v); end
   endtask

`ifdef UART_LOOPBACK_EN
   task automatic test_loopback();
      logic [15:0] v;
      do_reset();
      wr(16'h3, 16'h0094);
      peek(16'h3, v);
      total++; if (v !== 16'h0094) begin bad++; $display("FAIL lb_ctrl got=%h exp=0094", v); end
      wr(16'h0, 16'h007E);
      v = '0;
      for (int c = 0; c < 3 && v[0] !== 1'b1; c++) peek(16'h1, v);
      rd(16'h0, v);
      total++; if (v !== 16'h007E) begin bad++; $display("FAIL lb_data got=%h exp=007e", v); end
      total++; if (loads.size() !== 0) begin bad++; $display("FAIL lb_no_load got=%0d exp=0", loads.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_ctrl();
      test_tx();
      test_tx_ovf();
      test_rx_full();
      test_interrupt();
      test_ferr();
`ifdef UART_LOOPBACK_EN
      test_loopback();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
